// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the boot-time program loader
package loader_pkg;

  localparam int LOADER_ADDR_W = 8;
  localparam int LOADER_DATA_W = 8;

  // A LEN byte of zero encodes a full 2^ADDR_W-word image.
  localparam bit LEN_ZERO_MEANS_MAX = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - length-prefixed checksummed stream loader into program memory
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W,
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_waddr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_count
);

  loader_state_t state, state_next;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] csum_total;
  logic [ADDR_W:0]   len_decoded;
  logic              xfer;
  logic              csum_ok;

  assign xfer       = in_valid && in_ready;
  assign csum_total = sum + in_data;
  assign csum_ok    = (csum_total == '0);

  // LEN of zero stands for the full address space; 256 needs the extra bit.
  assign len_decoded = (LEN_ZERO_MEANS_MAX && (in_data == '0))
                       ? {1'b1, {ADDR_W{1'b0}}}
                       : (ADDR_W+1)'(in_data);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start only matters outside an active load.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_LEN;
      ST_LEN:   if (xfer) state_next = ST_DATA;
      ST_DATA:  if (xfer && (remaining == (ADDR_W+1)'(1))) state_next = ST_CSUM;
      ST_CSUM:  if (xfer) state_next = csum_ok ? ST_DONE : ST_ERROR;
      ST_DONE:  if (start) state_next = ST_LEN;
      ST_ERROR: if (start) state_next = ST_LEN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath, write port and status flags, all registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready   <= 1'b0;
      pm_we      <= 1'b0;
      pm_waddr   <= '0;
      pm_wdata   <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      byte_count <= '0;
      addr       <= '0;
      remaining  <= '0;
      sum        <= '0;
    end else begin
      in_ready <= (state_next == ST_LEN) || (state_next == ST_DATA) ||
                  (state_next == ST_CSUM);
      pm_we    <= 1'b0;

      // A new load re-holds the core and forgets the previous verdict.
      if ((state_next == ST_LEN) && (state != ST_LEN)) begin
        cpu_hold  <= 1'b1;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end

      case (state)
        ST_LEN: begin
          if (xfer) begin
            remaining  <= len_decoded;
            sum        <= '0;
            addr       <= '0;
            byte_count <= '0;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            pm_we      <= 1'b1;
            pm_waddr   <= addr;
            pm_wdata   <= in_data;
            // Wraps to 0 after the 0xFF write of a full image; never used.
            addr       <= addr + 1'b1;
            sum        <= csum_total;
            byte_count <= byte_count + 1'b1;
            remaining  <= remaining - 1'b1;
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            load_done <= csum_ok;
            load_err  <= !csum_ok;
            cpu_hold  <= !csum_ok;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       pm_we;
  logic [7:0] pm_waddr;
  logic [7:0] pm_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [8:0] byte_count;

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .pm_we(pm_we),
    .pm_waddr(pm_waddr), .pm_wdata(pm_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected writes as {addr, data}, in order; memories: what the DUT wrote
  // versus what the stream rules say program memory should now hold.
  int         exp_wr[$];
  logic [7:0] tb_mem[256];
  logic [7:0] ref_mem[256];
  logic [7:0] img[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Write-port monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (pm_we) begin
      if (exp_wr.size() == 0) begin
        check("spurious_we", {31'b0, pm_we}, 32'd0);
      end else begin
        check("wr_addr_data", {16'b0, pm_waddr, pm_wdata}, exp_wr.pop_front());
      end
      tb_mem[pm_waddr] = pm_wdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit with_start);
    int  waited;
    logic r;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    waited   = 0;
    forever begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) break;
      waited++;
      if (waited > 20) begin
        check("ready_timeout", {31'b0, r}, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  function automatic bit pick_gap(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic compare_mem();
    int mism = 0;
    for (int j = 0; j < 256; j++) if (tb_mem[j] !== ref_mem[j]) mism++;
    check("mem_image", mism, 32'd0);
  endtask

  // Pulse start, stream LEN/data/CSUM from img[0..n-1], then check the verdict.
  task automatic do_load(input int n, input logic [7:0] csum, input int gap_mode,
                         input int start_at);
    int sum = 0;
    bit ok;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_hold", {31'b0, cpu_hold}, 32'd1);
    check("start_done_clr", {31'b0, load_done}, 32'd0);
    check("start_err_clr", {31'b0, load_err}, 32'd0);
    check("start_ready", {31'b0, in_ready}, 32'd1);
    send_byte(8'(n), pick_gap(gap_mode), 1'b0);
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back((i << 8) | int'(img[i]));
      ref_mem[i] = img[i];
      sum += int'(img[i]);
      send_byte(img[i], pick_gap(gap_mode), i == start_at);
    end
    send_byte(csum, pick_gap(gap_mode), 1'b0);
    ok = (((sum + int'(csum)) % 256) == 0);
    check("load_done", {31'b0, load_done}, {31'b0, ok});
    check("load_err", {31'b0, load_err}, {31'b0, !ok});
    check("cpu_hold", {31'b0, cpu_hold}, {31'b0, !ok});
    check("byte_count", {23'b0, byte_count}, n);
    check("ready_after", {31'b0, in_ready}, 32'd0);
    check("writes_pending", exp_wr.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    compare_mem();
  endtask

  initial begin
    for (int j = 0; j < 256; j++) begin
      tb_mem[j]  = 8'h00;
      ref_mem[j] = 8'h00;
    end

    // Reset, with start held high to show reset wins.
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_pm_we", {31'b0, pm_we}, 32'd0);
    check("rst_pm_waddr", {24'b0, pm_waddr}, 32'd0);
    check("rst_pm_wdata", {24'b0, pm_wdata}, 32'd0);
    check("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check("rst_load_done", {31'b0, load_done}, 32'd0);
    check("rst_load_err", {31'b0, load_err}, 32'd0);
    check("rst_byte_count", {23'b0, byte_count}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", {31'b0, in_ready}, 32'd0);

    // Good load from the test plan.
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
    do_load(3, 8'h64, 0, -1);
    // Bad checksum, from DONE.
    do_load(3, 8'h65, 0, -1);
    // Full image with i at address i.
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    do_load(256, 8'h80, 0, -1);
    // Backpressure gaps, plus start asserted mid-DATA.
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
    do_load(3, 8'h64, 1, -1);
    do_load(3, 8'h64, 0, 1);

    // Reset after the second data byte.
    img[0] = 8'hA5; img[1] = 8'h5A; img[2] = 8'hC3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back((i << 8) | int'(img[i]));
      ref_mem[i] = img[i];
      send_byte(img[i], 1'b0, 1'b0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_hold", {31'b0, cpu_hold}, 32'd1);
    check("midrst_pm_we", {31'b0, pm_we}, 32'd0);
    check("midrst_count", {23'b0, byte_count}, 32'd0);
    check("midrst_done", {31'b0, load_done}, 32'd0);
    check("midrst_pending", exp_wr.size(), 32'd0);
    exp_wr.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
    do_load(3, 8'h64, 0, -1);

    // Randomized loads against the stream rules.
    for (int k = 0; k < 10; k++) begin
      int n;
      int s = 0;
      logic [7:0] cs;
      n = ($urandom_range(0, 7) == 0) ? 256 : int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) begin
        img[i] = 8'($urandom);
        s += int'(img[i]);
      end
      cs = 8'((256 - (s % 256)) % 256);
      if ($urandom_range(0, 2) == 0) cs = cs + 8'($urandom_range(1, 255));
      do_load(n, cs, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader sitting directly upstream of `program_memory`: receives a length-prefixed, checksummed byte stream over a valid/ready interface, writes it into program memory through a dedicated write port, and holds the processor in reset until a load completes cleanly. Its `cpu_hold` output gates `reset` into the microprocessor. Once released, the core fetches from the freshly written image.

## Interface
- `ADDR_W`, 8, program memory address width (256 words).
- `DATA_W`, 8, program word width; stream bytes map 1:1 to words.
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a new load from IDLE, DONE or ERROR.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  DATA_W  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `pm_we`  out  1  program memory write strobe.
- `pm_waddr`  out  ADDR_W  write address.
- `pm_wdata`  out  DATA_W  write data.
- `cpu_hold`  out  1  high = processor held in reset.
- `load_done`  out  1  high = last load succeeded.
- `load_err`  out  1  high = last load failed checksum.
- `byte_count`  out  ADDR_W+1  data bytes written in current/last load.

## Operation
- Stream format: LEN byte, then N data bytes, then CSUM byte. N = LEN, with LEN = 0 meaning 256.
- Checksum rule: (sum of data bytes + CSUM) mod 256 must equal 0.
- States:
  - IDLE: `in_ready`=0; `start` → LEN.
  - LEN: accept one byte; latch remaining = (LEN==0 ? 256 : LEN); clear sum, address, `byte_count`; → DATA.
  - DATA: each accepted byte is written to the current address; address +1; sum += byte; `byte_count` +1. After the Nth byte → CSUM.
  - CSUM: accept one byte. If sum+byte == 0 mod 256 → DONE, else → ERROR.
  - DONE: `load_done`=1, `cpu_hold`=0, `in_ready`=0; `start` → LEN (re-hold CPU).
  - ERROR: `load_err`=1, `cpu_hold`=1, `in_ready`=0; `start` → LEN.
- Handshake: a byte transfers only on `in_valid && in_ready`. `in_ready` is high in LEN, DATA and CSUM only. Gaps in `in_valid` stall without side effects.
- `start` is ignored in LEN/DATA/CSUM.
- Entering LEN clears `load_done` and `load_err` and sets `cpu_hold`=1 that cycle.
- Address arithmetic: ADDR_W bits. For N=256 the final write is at 0xFF; the internal increment wraps to 0 and is unused. `byte_count` is ADDR_W+1 bits so 256 is representable.
- Sum is DATA_W bits, modulo 2^DATA_W.
- Writes always start at address 0. Words beyond N keep their prior contents.

## Timing
- Reset values: `in_ready`=0, `pm_we`=0, `pm_waddr`=0, `pm_wdata`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0, `byte_count`=0, state IDLE.
- `pm_we`/`pm_waddr`/`pm_wdata` are registered: asserted for exactly one cycle, the cycle after the data handshake.
- `load_done`/`load_err`/`cpu_hold` update the cycle after the CSUM handshake. The last `pm_we` precedes this by at least one cycle.
- `in_ready` is registered from the next state. Maximum throughput is one byte per cycle, including back-to-back LEN→DATA→CSUM.
- Reset mid-load: returns to IDLE next edge with all outputs at reset values. A pending write is dropped. Partial memory contents are left as-is.
- `start` coincident with reset low: reset wins.

## Structure
- Shared package `loader_pkg`:
  - state enum (IDLE, LEN, DATA, CSUM, DONE, ERROR);
  - `LOADER_ADDR_W`, `LOADER_DATA_W`;
  - `LEN_ZERO_MEANS_MAX` constant.
- Single module. No sub-module is warranted; the checksum accumulator stays inline.
- Top-level integration:
  - core reset = `reset` AND NOT `cpu_hold`;
  - `program_memory` gains a write port driven by `pm_we`/`pm_waddr`/`pm_wdata`.

## Test plan
- Good load: `start`; stream 0x03,0x12,0x34,0x56,0x64 → writes 0x12@0, 0x34@1, 0x56@2; `load_done`=1, `cpu_hold`=0, `byte_count`=3.
- Bad checksum: same stream with CSUM 0x65 → three writes occur; `load_err`=1, `cpu_hold` stays 1, `load_done`=0.
- Full image: LEN=0x00, data byte i = i for i=0..255, CSUM=0x80 → 256 writes at 0x00..0xFF; `byte_count`=256; `load_done`=1.
- Backpressure/gaps: good 3-byte load with `in_valid` toggling every other cycle → identical writes and result; no write on idle cycles.
- Reset mid-load: drop `reset` after the second data byte → next cycle IDLE, `cpu_hold`=1, `pm_we`=0, `byte_count`=0. A fresh good load then succeeds.
- `start` during DATA is ignored (no restart, address continues); `start` in DONE → `cpu_hold` rises and `load_done` clears next cycle.
